alu_seq: RTL and testbench

Multi-cycle sequencer wrapped around the team's combinational Hack ALU. It accepts one operation per start handshake: either a single pass-through ALU operation with caller-supplied control bits, or a 16-bit multiply. The multiply is built from repeated ALU additions in a shift-and-add loop. It sits between the CPU/host control logic and the ALU and owns the ALU's control inputs.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_alu.sv | 39 +++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ALU1 = 3'd1,
        MADD = 3'd2,
        MDBL = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic OP_ALU = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Bit positions inside ctrl = {zx,nx,zy,ny,f,no}
    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] CTRL_ADD = 6'b000010;
    localparam logic [5:0] CTRL_SUB = 6'b010011;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational Hack ALU (zero/negate inputs, add or and, negate out).
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_y0;
    logic [WIDTH-1:0] w_y1;
    logic [WIDTH-1:0] w_f;

    assign w_x0 = zx ? '0 : x;
    assign w_x1 = nx ? ~w_x0 : w_x0;
    assign w_y0 = zy ? '0 : y;
    assign w_y1 = ny ? ~w_y0 : w_y0;
    assign w_f  = f  ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign out  = no ? ~w_f : w_f;
    assign zr   = (out == '0);
    assign ng   = out[WIDTH-1];

endmodule : alu
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequencer around the Hack ALU: single ALU op or shift-and-add multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [5:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_cnt;
    logic [5:0]       r_ctrl;
    logic             r_op;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_alu_x;
    logic [WIDTH-1:0] w_alu_y;
    logic [5:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_alu_zr_unused;
    logic             w_alu_ng_unused;
    logic             w_last;

    // Loop ends after 16 iterations or once no multiplier bits remain
    assign w_last = (r_cnt == 4'd15) || (r_y[WIDTH-1:1] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (op == OP_MUL) ? MADD : ALU1;
            ALU1:    w_state_nxt = DONE;
            MADD:    w_state_nxt = MDBL;
            MDBL:    w_state_nxt = w_last ? DONE : MADD;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_alu_x    = r_x;
        w_alu_y    = r_y;
        w_alu_ctrl = CTRL_ADD;
        case (r_state)
            ALU1: begin
                if (r_op == OP_ALU) w_alu_ctrl = r_ctrl;
            end
            MADD: begin
                w_alu_x = r_acc;
                w_alu_y = r_x;
            end
            MDBL: begin
                w_alu_x = r_x;
                w_alu_y = r_x;
            end
            default: begin
                w_alu_x = r_x;
                w_alu_y = r_y;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ctrl   <= '0;
            r_op     <= OP_ALU;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x    <= a;
                        r_y    <= b;
                        r_ctrl <= ctrl;
                        r_op   <= op;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ALU1: r_result <= w_alu_out;
                MADD: begin
                    if (r_y[0]) r_acc <= w_alu_out;
                end
                MDBL: begin
                    r_x   <= w_alu_out;
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) r_result <= r_acc;
                end
                default: ;
            endcase
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x   (w_alu_x),
        .y   (w_alu_y),
        .zx  (w_alu_ctrl[CTRL_ZX]),
        .nx  (w_alu_ctrl[CTRL_NX]),
        .zy  (w_alu_ctrl[CTRL_ZY]),
        .ny  (w_alu_ctrl[CTRL_NY]),
        .f   (w_alu_ctrl[CTRL_F]),
        .no  (w_alu_ctrl[CTRL_NO]),
        .out (w_alu_out),
        .zr  (w_alu_zr_unused),
        .ng  (w_alu_ng_unused)
    );

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign zr     = (r_result == '0);
    assign ng     = r_result[WIDTH-1];

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [5:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zr;
    logic        ng;

    int n_checks;
    int n_fail;

    localparam logic [5:0] C_ADD = 6'b000010;
    localparam logic [5:0] C_SUB = 6'b010011;
    localparam logic [5:0] C_AND = 6'b000000;

    alu_seq #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .ctrl   (ctrl),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zr     (zr),
        .ng     (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for IDLE, then presents one request for exactly one edge
    task automatic do_start(input logic o, input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        op = o; ctrl = c; a = x; b = y;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output logic got);
        cyc = 1;
        while (done !== 1'b1 && cyc < limit) begin
            step();
            cyc++;
        end
        got = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
        n_checks++; if ({zr, ng} !== 2'b10) begin n_fail++; $display("FAIL reset_flags: got zr=%b ng=%b want zr=1 ng=0", zr, ng); end
    endtask

    task automatic test_single_ops();
        int cyc; logic got;
        do_start(1'b0, C_ADD, 16'd5, 16'd7);
        // Late input changes must not disturb the latched operation
        ctrl = C_SUB; a = 16'h1111; b = 16'h2222; op = 1'b1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
        wait_done(10, cyc, got);
        n_checks++; if (!got || cyc != 2) begin n_fail++; $display("FAIL add_latency: got %0d (done=%b) want 2", cyc, got); end
        n_checks++; if (result !== 16'h000C) begin n_fail++; $display("FAIL add_result: got %h want 000C", result); end
        n_checks++; if ({zr, ng} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got zr=%b ng=%b want 0 0", zr, ng); end

        do_start(1'b0, C_SUB, 16'd3, 16'd5);
        wait_done(10, cyc, got);
        n_checks++; if (!got || cyc != 2) begin n_fail++; $display("FAIL sub_latency: got %0d want 2", cyc); end
        n_checks++; if (result !== 16'hFFFE) begin n_fail++; $display("FAIL sub_result: got %h want FFFE", result); end
        n_checks++; if ({zr, ng} !== 2'b01) begin n_fail++; $display("FAIL sub_flags: got zr=%b ng=%b want 0 1", zr, ng); end

        do_start(1'b0, C_AND, 16'h0F0F, 16'h00FF);
        wait_done(10, cyc, got);
        n_checks++; if (result !== 16'h000F) begin n_fail++; $display("FAIL and_result: got %h want 000F", result); end
    endtask

    task automatic test_multiply();
        int cyc; logic got;
        do_start(1'b1, 6'b111111, 16'd123, 16'd45);
        a = 16'h0; b = 16'h0;
        wait_done(40, cyc, got);
        n_checks++; if (!got || cyc != 13) begin n_fail++; $display("FAIL mul_latency: got %0d want 13", cyc); end
        n_checks++; if (result !== 16'h159F) begin n_fail++; $display("FAIL mul_result: got %h want 159F", result); end
    endtask

    task automatic test_busy_ignore();
        int c; int ndone;
        ndone = 0;
        do_start(1'b1, C_ADD, 16'd123, 16'd45);
        for (c = 1; c < 40; c++) begin
            step();
            if (start) start = 1'b0;
            if (c == 3) begin
                op = 1'b0; ctrl = C_ADD; a = 16'd1; b = 16'd1; start = 1'b1;
            end
            if (done) begin
                ndone++;
                start = 1'b1;
            end
        end
        start = 1'b0;
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_after: got %b want 0", busy); end
        n_checks++; if (result !== 16'h159F) begin n_fail++; $display("FAIL ignore_result: got %h want 159F", result); end
    endtask

    task automatic test_mul_boundaries();
        int cyc; logic got;
        do_start(1'b1, C_ADD, 16'hFFFF, 16'h8000);
        wait_done(40, cyc, got);
        n_checks++; if (!got || cyc != 33) begin n_fail++; $display("FAIL mulmax_latency: got %0d want 33", cyc); end
        n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL mulmax_result: got %h want 8000", result); end
        n_checks++; if (ng !== 1'b1) begin n_fail++; $display("FAIL mulmax_ng: got %b want 1", ng); end

        do_start(1'b1, C_ADD, 16'h1234, 16'h0000);
        step();
        n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL mulzero_hold: got %h want 8000", result); end
        cyc = 2;
        while (done !== 1'b1 && cyc < 40) begin step(); cyc++; end
        n_checks++; if (done !== 1'b1 || cyc != 3) begin n_fail++; $display("FAIL mulzero_latency: got %0d want 3", cyc); end
        n_checks++; if (result !== 16'h0000 || zr !== 1'b1) begin n_fail++; $display("FAIL mulzero_result: got %h zr=%b want 0000 zr=1", result, zr); end
    endtask

    task automatic test_back_to_back();
        int c; int first; int second;
        first = 0; second = 0;
        while (busy) step();
        op = 1'b0; ctrl = C_ADD; a = 16'd2; b = 16'd3;
        start = 1'b1;
        step();
        for (c = 1; c <= 6; c++) begin
            if (c > 1) step();
            if (done) begin
                if (first == 0) first = c; else if (second == 0) second = c;
            end
            if (c == 4) begin
                n_checks++; if (result !== 16'h0005) begin n_fail++; $display("FAIL b2b_hold: got %h want 0005", result); end
            end
        end
        start = 1'b0;
        n_checks++; if (first != 2 || second != 5) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d want 2,5", first, second); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_mul();
        int ndone; int cyc; logic got;
        ndone = 0;
        do_start(1'b1, C_ADD, 16'd7, 16'h00FF);
        repeat (4) step();
        reset = 1'b1;
        op = 1'b0; ctrl = C_ADD; a = 16'd1; b = 16'd1; start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got busy=%b done=%b want 0 0", busy, done); end
        n_checks++; if (result !== 16'h0000 || zr !== 1'b1 || ng !== 1'b0) begin n_fail++; $display("FAIL midreset_result: got %h zr=%b ng=%b want 0000 1 0", result, zr, ng); end
        repeat (20) begin
            step();
            if (done || busy) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL midreset_activity: got %0d active cycles want 0", ndone); end
        do_start(1'b0, C_ADD, 16'd1, 16'd1);
        wait_done(10, cyc, got);
        n_checks++; if (!got || result !== 16'h0002) begin n_fail++; $display("FAIL postreset_add: got %h (done=%b) want 0002", result, got); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; op = 1'b0; ctrl = 6'd0; a = 16'd0; b = 16'd0;
        test_reset();
        test_single_ops();
        test_multiply();
        test_busy_ignore();
        test_mul_boundaries();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
